// File: rtl/ram_rr_arb.sv
// Round-robin Wishbone-classic arbiter: N masters share one memory slave bus, with
// per-transaction timeout (error return) and master-abort handling.
module ram_rr_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [N-1:0]    m_cyc,
    input  logic [N-1:0]    m_we,
    input  logic [4*N-1:0]  m_sel,
    input  logic [AW*N-1:0] m_adr,
    input  logic [32*N-1:0] m_dat,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic [32*N-1:0] m_rdt,
    output logic            x_cyc,
    output logic            x_we,
    output logic [3:0]      x_sel,
    output logic [AW-1:0]   x_adr,
    output logic [31:0]     x_dat,
    input  logic            x_ack,
    input  logic [31:0]     x_rdt,
    output logic [N-1:0]    grant
);
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] gidx_q, gidx_d;
    logic [LW-1:0] last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          busy;
    logic          req_found;
    logic [LW-1:0] pick;
    logic          timer_end;
    logic          done;
    int unsigned   j;
    int unsigned   g;

    // First requester searching upward from last+1, so the last served master ranks lowest.
    always_comb begin
        req_found = 1'b0;
        pick      = '0;
        j         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(last_q) + 32'd1 + i) % N;
            if (!req_found && m_cyc[j]) begin
                req_found = 1'b1;
                pick      = LW'(j);
            end
        end
    end

    assign busy      = (state_q == StBusy);
    assign g         = 32'(gidx_q);
    assign timer_end = (timer_q == TLAST);
    assign done      = x_ack || !m_cyc[gidx_q] || timer_end;

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    state_d = StBusy;
                    gidx_d  = pick;
                    timer_d = '0;
                end
            end
            StBusy: begin
                if (done) begin
                    state_d = StRelease;
                    last_d  = gidx_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            last_q  <= LW'(N - 1);
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    // Outside BUSY every output is forced low so no master bus leaks onto the slave.
    always_comb begin
        x_cyc = 1'b0;
        x_we  = 1'b0;
        x_sel = '0;
        x_adr = '0;
        x_dat = '0;
        grant = '0;
        m_ack = '0;
        m_err = '0;
        m_rdt = '0;
        if (busy) begin
            x_cyc           = m_cyc[gidx_q];
            x_we            = m_we[gidx_q];
            x_sel           = m_sel[4*g +: 4];
            x_adr           = m_adr[AW*g +: AW];
            x_dat           = m_dat[32*g +: 32];
            grant[gidx_q]   = 1'b1;
            m_ack[gidx_q]   = x_ack;
            m_err[gidx_q]   = timer_end && !x_ack;
            if (x_ack) begin
                m_rdt[32*g +: 32] = x_rdt;
            end
        end
    end

endmodule

// File: tb/tb_ram_rr_arb.sv
// Directed bench for ram_rr_arb: table of single transactions plus hand sequences for
// rotation, alternation, abort, timeout and asynchronous reset.
module tb_ram_rr_arb;
    logic         clk;
    logic         rst_n;
    logic [3:0]   m_cyc, m_we, m_ack, m_err, grant;
    logic [15:0]  m_sel;
    logic [127:0] m_adr, m_dat, m_rdt;
    logic         x_cyc, x_we, x_ack;
    logic [3:0]   x_sel;
    logic [31:0]  x_adr, x_dat, x_rdt;

    int total = 0;
    int bad   = 0;

    ram_rr_arb #(.N(4), .AW(32), .TIMEOUT(256)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
        .m_ack(m_ack), .m_err(m_err), .m_rdt(m_rdt),
        .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
        .x_ack(x_ack), .x_rdt(x_rdt), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-wait-state memory slave; slave_on=0 models a slave that never acks.
    logic        slave_on;
    logic [31:0] mem [0:63];
    int          wcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ack <= 1'b0;
            wcnt  <= 0;
        end else if (!x_cyc || x_ack) begin
            x_ack <= 1'b0;
            wcnt  <= 0;
        end else if (slave_on && wcnt == 1) begin
            x_ack <= 1'b1;
            if (x_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (x_sel[b]) mem[x_adr[7:2]][8*b +: 8] <= x_dat[8*b +: 8];
                end
            end
        end else if (slave_on) begin
            wcnt <= wcnt + 1;
        end
    end
    assign x_rdt = x_ack ? mem[x_adr[7:2]] : 32'h0;

    typedef struct {
        int          mst;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rexp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic set_m(input int m, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_we[m]          = we;
        m_sel[4*m +: 4]  = sel;
        m_adr[32*m +: 32] = adr;
        m_dat[32*m +: 32] = dat;
    endtask

    // Called right after a negedge sample; advances one negedge per cycle without ack.
    task automatic wait_ack(input int m, input int budget, output int n);
        n = 0;
        while (!m_ack[m] && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Starts and ends one time unit after a clock edge that leaves the arbiter in IDLE.
    task automatic do_txn(input vec_t v);
        int n;
        logic [127:0] rd;
        set_m(v.mst, v.we, v.sel, v.adr, v.dat);
        m_cyc[v.mst] = 1'b1;
        @(negedge clk);
        chk("pre_grant_xcyc", x_cyc, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("grant", grant, 128'(1) << v.mst);
        chk("x_cyc", x_cyc, 1);
        chk("x_adr", x_adr, v.adr);
        chk("x_we", x_we, v.we);
        chk("x_sel", x_sel, v.sel);
        chk("x_dat", x_dat, v.we ? v.dat : 32'h0);
        chk("rdt_pre_ack", m_rdt, 0);
        wait_ack(v.mst, 20, n);
        chk("ack_latency", n, 2);
        chk("err_with_ack", m_err, 0);
        chk("ack_onehot", m_ack, 128'(1) << v.mst);
        if (!v.we) begin
            rd = 128'(v.rexp) << (32 * v.mst);
            chk("read_data", m_rdt, rd);
        end
        @(posedge clk); #1;
        m_cyc[v.mst] = 1'b0;
        @(negedge clk);
        chk("release_bus", {x_cyc, x_we, x_sel, x_adr, x_dat}, 0);
        chk("release_ack_grant", {m_ack, grant}, 0);
        @(posedge clk); #1;
    endtask

    vec_t vt [6];
    vec_t rv;
    int   n;
    int   got;
    logic [31:0] dmy;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{mst: 2, we: 1'b1, sel: 4'hF, adr: 32'h10, dat: 32'hCAFECAFE, rexp: 32'h0};
        vt[1] = '{mst: 2, we: 1'b0, sel: 4'hF, adr: 32'h10, dat: 32'h0, rexp: 32'hCAFECAFE};
        vt[2] = '{mst: 0, we: 1'b1, sel: 4'hF, adr: 32'h20, dat: 32'h12345678, rexp: 32'h0};
        vt[3] = '{mst: 1, we: 1'b1, sel: 4'h5, adr: 32'h20, dat: 32'hAABBCCDD, rexp: 32'h0};
        vt[4] = '{mst: 3, we: 1'b0, sel: 4'hF, adr: 32'h20, dat: 32'h0, rexp: 32'h12BB56DD};
        vt[5] = '{mst: 1, we: 1'b0, sel: 4'hF, adr: 32'h10, dat: 32'h0, rexp: 32'hCAFECAFE};

        // Reset with every master requesting: nothing may be granted.
        rst_n = 1'b0; slave_on = 1'b1;
        m_cyc = 4'hF; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", {grant, x_cyc, m_ack, m_err, x_adr, x_dat}, 0);
        m_cyc = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_txn(vt[i]);

        // Abort: master 2 drops cyc after 3 BUSY cycles, pending master 3 follows.
        slave_on = 1'b0;
        set_m(2, 1'b0, 4'hF, 32'h80, 32'h0);
        set_m(3, 1'b0, 4'hF, 32'h84, 32'h0);
        m_cyc = 4'b1100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_grant2", grant, 4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_xcyc", x_cyc, 1);
        @(posedge clk); #1;
        m_cyc[2] = 1'b0;
        #1;
        chk("abort_xcyc_drop", x_cyc, 0);
        chk("abort_no_ack_err", {m_ack, m_err}, 0);
        @(posedge clk); #1;
        chk("abort_release", {grant, x_cyc}, 0);
        @(posedge clk); #1;
        chk("abort_idle", {grant, x_cyc}, 0);
        @(posedge clk); #1;
        chk("abort_grant3", grant, 4'b1000);
        chk("abort_x_adr3", x_adr, 32'h84);
        m_cyc[3] = 1'b0;
        #1;
        chk("abort3_no_ack", {m_ack, m_err}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Timeout: slave silent, master 0 reads, master 1 waits its turn.
        set_m(0, 1'b0, 4'hF, 32'h40, 32'h0);
        set_m(1, 1'b1, 4'hF, 32'h44, 32'h55);
        m_cyc = 4'b0011;
        @(posedge clk); #1;
        @(negedge clk);
        n = 1;
        chk("to_grant0", grant, 4'b0001);
        while (m_err[0] == 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 256);
        chk("to_no_ack", m_ack, 0);
        chk("to_xcyc_held", x_cyc, 1);
        @(posedge clk); #1;
        m_cyc[0] = 1'b0;
        slave_on = 1'b1;
        @(negedge clk);
        chk("to_err_pulse", {m_err, x_cyc}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_next_grant", grant, 4'b0010);
        wait_ack(1, 20, n);
        chk("to_next_ack", n, 2);
        @(posedge clk); #1;
        m_cyc[1] = 1'b0;
        @(posedge clk); #1;

        // Async reset while ack is high on master 2.
        set_m(2, 1'b0, 4'hF, 32'h10, 32'h0);
        m_cyc[2] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        wait_ack(2, 20, n);
        chk("rst_pre_ack", m_ack, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", {x_cyc, grant, m_ack, m_rdt, x_adr}, 0);
        #1;
        m_cyc[2] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests after reset: order 0,1,2,3.
        for (int i = 0; i < 4; i++) set_m(i, 1'b1, 4'hF, 32'(4 * i), 32'(i));
        m_cyc = 4'hF;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n = 0;
            while (m_ack == 4'h0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            got = -1;
            for (int i = 0; i < 4; i++) if (m_ack[i]) got = i;
            chk("sim_order", got, t);
            @(posedge clk); #1;
            if (got >= 0) m_cyc[got] = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rv = '{mst: i, we: 1'b0, sel: 4'hF, adr: 32'(4 * i), dat: 32'h0, rexp: 32'(i)};
            do_txn(rv);
        end

        // Masters 1 and 3 re-request right after each ack: strict alternation.
        set_m(1, 1'b1, 4'hF, 32'h30, 32'h11);
        set_m(3, 1'b1, 4'hF, 32'h34, 32'h33);
        m_cyc = 4'b1010;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            n = 0;
            while (m_ack == 4'h0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            got = -1;
            for (int i = 0; i < 4; i++) if (m_ack[i]) got = i;
            chk("alt_order", got, (t % 2 == 0) ? 1 : 3);
            @(posedge clk); #1;
            if (got >= 0) m_cyc[got] = 1'b0;
            @(posedge clk); #1;
            if (t == 7) m_cyc = 4'b0000;
            else if (got >= 0) m_cyc[got] = 1'b1;
        end
        @(negedge clk);
        chk("final_idle", {grant, x_cyc}, 0);
        dmy = mem[13];
        chk("alt_write_mem", dmy, 32'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_rr_arb.md
Name: ram_rr_arb

Overview:
- N-port round-robin Wishbone-classic arbiter sharing one memory slave bus (x_*) between N masters (m_*), e.g. CPU, DMA, DSP engines into sp_ram.
- Extends the two-port fixed-priority sharing scheme with fair rotation, a per-transaction timeout with error return, and master-abort handling.
- Pure control and mux block; no storage beyond grant/state/counter.

Parameters:
- N, 4, number of masters (2..8).
- AW, 32, address width.
- TIMEOUT, 256, max cycles a granted transaction may wait for x_ack before error termination (>=2).

Ports:
- wb_clk  in  1  clock.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- m_cyc  in  N  per-master cycle request.
- m_we  in  N  per-master write enable.
- m_sel  in  4*N  byte selects, master i at [4i+3:4i].
- m_adr  in  AW*N  addresses, master i at [AW*i+AW-1:AW*i].
- m_dat  in  32*N  write data.
- m_ack  out  N  per-master ack.
- m_err  out  N  per-master timeout error.
- m_rdt  out  32*N  read data.
- x_cyc  out  1  slave cycle.
- x_we  out  1  slave write enable.
- x_sel  out  4  slave byte selects.
- x_adr  out  AW  slave address.
- x_dat  out  32  slave write data.
- x_ack  in  1  slave ack.
- x_rdt  in  32  slave read data.
- grant  out  N  one-hot current owner, for debug.

Behaviour:
- Reset (wb_rst_n low, async): state=IDLE, grant=0, last=N-1, timer=0.
  - All outputs are 0 while reset is low.
  - A reset mid-transaction drops x_cyc immediately and issues no ack.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - At a clock edge with any m_cyc high, grant <= first requester searching from last+1 upward modulo N.
  - State <= BUSY; timer <= 0.
- BUSY:
  - x_cyc/we/sel/adr/dat = granted master's signals, combinationally.
  - m_ack[g] = x_ack (combinational).
  - m_rdt[g] = x_rdt when x_ack is high, else 0.
  - On an edge with x_ack high: last <= g, grant <= 0, state <= RELEASE.
  - If m_cyc[g] goes low without x_ack (abort): same transition, no ack issued.
  - If timer == TIMEOUT-1 with no x_ack: m_err[g]=1 for that cycle, x_cyc held, then same transition. Error and ack are never both asserted.
  - Otherwise timer increments.
- RELEASE:
  - Exactly one cycle with x_cyc=0, which lets the served master deassert cyc.
  - Then go to IDLE. The IDLE arbitration happens on the next edge, so the gap between back-to-back transactions is 2 idle cycles on x_cyc.
- Latency: m_cyc high at edge k → x_cyc high after edge k (one registered cycle). Ack latency is that plus slave latency.
- Ungranted masters: m_ack=0, m_err=0, m_rdt=0 always.
- In IDLE/RELEASE, all x_* outputs are 0, including x_adr and x_dat (no leakage of master buses).
- Simultaneous requests: the rotation pointer decides. After reset, master 0 wins; the last served master gets lowest priority next round.
- A single persistent requester is re-granted every 3 cycles plus slave latency, with no starvation of others.
- Masters' signals must be stable from m_cyc rise to ack/err. The arbiter does not register the master buses.
- x_ack arriving in IDLE/RELEASE is ignored.

Test Plan:
- Single master 2 writes 0xCAFE_CAFE to 0x10 with a 1-wait slave.
  - x_cyc rises one cycle after m_cyc[2], and x_adr=0x10, x_dat=0xCAFE_CAFE, x_sel=4'hF.
  - m_ack[2] is a one-cycle pulse; all x_* return to 0 in RELEASE.
  - A readback returns 0xCAFE_CAFE on m_rdt[2] only during ack.
- Masters 0..3 request together, each writing distinct data 0x0000_000i to address 4*i, with the request held until ack.
  - Grant order is 0,1,2,3.
  - Readback of all four addresses returns the matching data.
- Masters 1 and 3 repeatedly re-request immediately after each ack for 8 transactions.
  - Grants alternate 1,3,1,3…, with neither served twice consecutively.
- Slave never acks; master 0 reads with TIMEOUT=256.
  - m_err[0] pulses 256 cycles after x_cyc rises, with m_ack[0]=0.
  - The next requester is then granted normally.
- Master 2 drops m_cyc after 3 cycles in BUSY with no ack.
  - x_cyc falls, with no m_ack/m_err.
  - Pending master 3 is granted 2 cycles later.
- wb_rst_n pulsed low mid-transaction.
  - x_cyc, grant and m_ack are 0 immediately, without waiting for a clock edge.
  - After release, master 0 wins the next simultaneous request.
